// File: rtl/mito_pkg.sv
// Shared codes for the MITO layer sequencer: mode, buffer bank and FSM states.
package mito_pkg;

  // Layer modes carried on the mode input.
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] CONVOL    = 2'b01;
  localparam logic [1:0] FULLY     = 2'b10;
  localparam logic [1:0] POOL      = 2'b11;

  // Main-buffer bank selects.
  localparam logic [1:0] BUF_IFM  = 2'd0;
  localparam logic [1:0] BUF_WGT  = 2'd1;
  localparam logic [1:0] BUF_BIAS = 2'd2;

  // Sequencer states.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_WGT  = 3'd1;
  localparam logic [2:0] LOAD_BIAS = 3'd2;
  localparam logic [2:0] LOAD_IFM  = 3'd3;
  localparam logic [2:0] EXEC      = 3'd4;
  localparam logic [2:0] WRITE     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  // Width of the beat / latency counters; holds every slot index of a bank.
  localparam int CNT_W = 4;

  // A start is rejected for the illegal mode code or an empty layer.
  function automatic logic start_ok(input logic [1:0] mode, input logic any_windows);
    return (mode != MODE_NONE) && any_windows;
  endfunction

endpackage

// File: rtl/mito_beat_counter.sv
// Loadable up-counter with enable and a terminal-count flag against a
// caller-supplied last value. Load wins over enable.
module mito_beat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, step, or hold.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/mito_layer_seq.sv
// MITO layer sequencer: loads weights/bias once per layer, then streams
// num_windows IFM windows, fires PE+ReLU or max-pool and commits each result.
module mito_layer_seq #(
  parameter int PE_ARRAY_SIZE = 9,
  parameter int POOL_SIZE     = 4,
  parameter int PE_LATENCY    = 3,
  parameter int RELU_LATENCY  = 1,
  parameter int POOL_LATENCY  = 1,
  parameter int WIN_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIN_W-1:0] num_windows,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             buf_wr_en,
  output logic [1:0]       buf_sel,
  output logic [3:0]       buf_addr,
  output logic             pe_en,
  output logic             relu_en,
  output logic             pool_en,
  output logic             ofm_wr_en,
  output logic [WIN_W-1:0] ofm_addr,
  output logic             out_sel,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import mito_pkg::*;

  // Last slot / last EXEC cycle for each phase, as counter terminal values.
  localparam logic [CNT_W-1:0] PE_LAST   = CNT_W'(PE_ARRAY_SIZE - 1);
  localparam logic [CNT_W-1:0] POOL_LAST = CNT_W'(POOL_SIZE - 1);
  localparam logic [CNT_W-1:0] CONV_EXEC = CNT_W'(PE_LATENCY + RELU_LATENCY);
  localparam logic [CNT_W-1:0] POOL_EXEC = CNT_W'(POOL_LATENCY);
  localparam logic [CNT_W-1:0] RELU_AT   = CNT_W'(PE_LATENCY);

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIN_W-1:0] num_win_q, num_win_d;
  logic [WIN_W-1:0] win_idx_q, win_idx_d;
  logic             err_q, err_d;

  logic             live, is_pool, in_load, beat;
  logic [WIN_W:0]   win_next;
  logic [CNT_W-1:0] ld_cnt, ld_term, ex_cnt, ex_term;
  logic             ld_tc, ex_tc;

  // rst gates the strobes in its own cycle so an abort never writes again.
  assign live     = !rst;
  assign is_pool  = (mode_q == POOL);
  assign in_load  = (state_q == LOAD_WGT) || (state_q == LOAD_BIAS) || (state_q == LOAD_IFM);
  assign in_ready = in_load && live;
  assign beat     = in_valid && in_ready;
  // One extra bit so the last window of a full-range layer cannot wrap.
  assign win_next = {1'b0, win_idx_q} + {{WIN_W{1'b0}}, 1'b1};

  // Terminal values for the load-beat and EXEC-latency counters.
  always_comb begin
    ld_term = PE_LAST;
    if (state_q == LOAD_BIAS)     ld_term = '0;
    else if (state_q == LOAD_IFM) ld_term = is_pool ? POOL_LAST : PE_LAST;
    ex_term = is_pool ? POOL_EXEC : CONV_EXEC;
  end

  mito_beat_counter #(.W(CNT_W)) u_load_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q == IDLE) || (beat && ld_tc)),
    .load_val ('0),
    .en       (beat),
    .term     (ld_term),
    .cnt      (ld_cnt),
    .tc       (ld_tc)
  );

  mito_beat_counter #(.W(CNT_W)) u_exec_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q != EXEC) || ex_tc),
    .load_val ('0),
    .en       (state_q == EXEC),
    .term     (ex_term),
    .cnt      (ex_cnt),
    .tc       (ex_tc)
  );

  // Next-state logic: start validation, phase sequencing and window looping.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_win_d = num_win_q;
    win_idx_d = win_idx_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode;
          num_win_d = num_windows;
          win_idx_d = '0;
          if (!start_ok(mode, num_windows != '0)) err_d   = 1'b1;
          else if (mode == POOL)                  state_d = LOAD_IFM;
          else                                    state_d = LOAD_WGT;
        end
      end
      LOAD_WGT:  if (beat && ld_tc) state_d = LOAD_BIAS;
      LOAD_BIAS: if (beat && ld_tc) state_d = LOAD_IFM;
      LOAD_IFM:  if (beat && ld_tc) state_d = EXEC;
      EXEC:      if (ex_tc)         state_d = WRITE;
      WRITE: begin
        win_idx_d = win_next[WIN_W-1:0];
        state_d   = (win_next < {1'b0, num_win_q}) ? LOAD_IFM : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes decoded from state and counters.
  always_comb begin
    buf_wr_en = beat;
    buf_addr  = beat ? ld_cnt : '0;
    buf_sel   = BUF_IFM;
    if (beat && state_q == LOAD_WGT)  buf_sel = BUF_WGT;
    if (beat && state_q == LOAD_BIAS) buf_sel = BUF_BIAS;
    pe_en     = live && (state_q == EXEC) && !is_pool && (ex_cnt == '0);
    relu_en   = live && (state_q == EXEC) && !is_pool && (ex_cnt == RELU_AT);
    pool_en   = live && (state_q == EXEC) && is_pool && (ex_cnt == '0);
    ofm_wr_en = live && (state_q == WRITE);
    ofm_addr  = ofm_wr_en ? win_idx_q : '0;
    out_sel   = ofm_wr_en && is_pool;
    busy      = (state_q != IDLE);
    done      = live && (state_q == DONE);
    err       = err_q;
  end

  // State and latched layer parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      num_win_q <= '0;
      win_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_win_q <= num_win_d;
      win_idx_q <= win_idx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mito_layer_seq.sv
// Scoreboard bench for mito_layer_seq: a layer-level model queues the expected
// event stream, a monitor pops it as the DUT raises strobes and checks timing.
module tb_mito_layer_seq;

  localparam int WIN_W = 16;
  localparam int EV_BUF = 0, EV_PE = 1, EV_RELU = 2, EV_POOL = 3,
                 EV_OFM = 4, EV_DONE = 5, EV_ERR = 6;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [WIN_W-1:0] num_windows = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, buf_wr_en, pe_en, relu_en, pool_en, ofm_wr_en;
  logic             out_sel, busy, done, err;
  logic [1:0]       buf_sel;
  logic [3:0]       buf_addr;
  logic [WIN_W-1:0] ofm_addr;

  int  total = 0;
  int  bad = 0;
  ev_t exp_q[$];

  mito_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_windows(num_windows),
    .in_valid(in_valid), .in_ready(in_ready), .buf_wr_en(buf_wr_en),
    .buf_sel(buf_sel), .buf_addr(buf_addr), .pe_en(pe_en), .relu_en(relu_en),
    .pool_en(pool_en), .ofm_wr_en(ofm_wr_en), .ofm_addr(ofm_addr),
    .out_sel(out_sel), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected event list for one layer, straight from the layer rules.
  task automatic model_build(input logic [1:0] m, input int n, output ev_t q[$]);
    int ifm_words;
    q = {};
    if (m == 2'b00 || n == 0) begin
      q.push_back('{EV_ERR, 0, 0});
      return;
    end
    if (m != 2'b11) begin
      for (int i = 0; i < 9; i++) q.push_back('{EV_BUF, 1, i});
      q.push_back('{EV_BUF, 2, 0});
    end
    ifm_words = (m == 2'b11) ? 4 : 9;
    for (int w = 0; w < n; w++) begin
      for (int i = 0; i < ifm_words; i++) q.push_back('{EV_BUF, 0, i});
      if (m == 2'b11) begin
        q.push_back('{EV_POOL, 0, 0});
        q.push_back('{EV_OFM, w, 1});
      end else begin
        q.push_back('{EV_PE, 0, 0});
        q.push_back('{EV_RELU, 0, 0});
        q.push_back('{EV_OFM, w, 0});
      end
    end
    q.push_back('{EV_DONE, 0, 0});
  endtask

  // Monitor: one strobe per cycle at most; pop and compare, then check spacing.
  int cyc = 0, last_buf_cyc = -100, pe_cyc = -100, pool_cyc = -100, ofm_cyc = -100;
  always @(negedge clk) begin
    int n_ev, kind, a, b;
    ev_t e;
    cyc++;
    if (!rst) begin
      n_ev = int'(buf_wr_en) + int'(pe_en) + int'(relu_en) + int'(pool_en)
           + int'(ofm_wr_en) + int'(done) + int'(err);
      kind = -1; a = 0; b = 0;
      if (buf_wr_en)      begin kind = EV_BUF; a = int'(buf_sel); b = int'(buf_addr); end
      else if (pe_en)     kind = EV_PE;
      else if (relu_en)   kind = EV_RELU;
      else if (pool_en)   kind = EV_POOL;
      else if (ofm_wr_en) begin kind = EV_OFM; a = int'(ofm_addr); b = int'(out_sel); end
      else if (done)      kind = EV_DONE;
      else if (err)       kind = EV_ERR;
      if (n_ev > 1) check(n_ev <= 1, "strobe_overlap", n_ev, 1);
      if (kind >= 0) begin
        if (exp_q.size() == 0) begin
          check(exp_q.size() != 0, "unexpected_event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          check(kind == e.kind && a == e.a && b == e.b, "event",
                (kind << 24) | (a << 4) | b, (e.kind << 24) | (e.a << 4) | e.b);
        end
        case (kind)
          EV_BUF:  begin check(in_valid, "write_needs_valid", int'(in_valid), 1); last_buf_cyc = cyc; end
          EV_PE:   begin check(cyc == last_buf_cyc + 1, "pe_after_load", cyc - last_buf_cyc, 1); pe_cyc = cyc; end
          EV_POOL: begin check(cyc == last_buf_cyc + 1, "pool_after_load", cyc - last_buf_cyc, 1); pool_cyc = cyc; end
          EV_RELU: check(cyc == pe_cyc + 3, "relu_delay", cyc - pe_cyc, 3);
          EV_OFM: begin
            if (out_sel) check(cyc == pool_cyc + 2, "ofm_after_pool", cyc - pool_cyc, 2);
            else         check(cyc == pe_cyc + 5, "ofm_after_pe", cyc - pe_cyc, 5);
            ofm_cyc = cyc;
          end
          EV_DONE: check(cyc == ofm_cyc + 1, "done_after_ofm", cyc - ofm_cyc, 1);
          EV_ERR:  check(!busy, "err_not_busy", int'(busy), 0);
          default: ;
        endcase
      end
    end
  end

  // vmode: 0 valid held high, 1 toggling, 2 random. perturb scrambles inputs mid-layer.
  task automatic run_layer(input logic [1:0] m, input int n, input int vmode, input bit perturb);
    ev_t q[$];
    bit  got;
    model_build(m, n, q);
    foreach (q[i]) exp_q.push_back(q[i]);
    @(posedge clk); #1;
    start = 1'b1; mode = m; num_windows = WIN_W'(n); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (m == 2'b00 || n == 0) begin
      repeat (3) @(posedge clk);
      #1 check(!busy, "idle_after_reject", int'(busy), 0);
      return;
    end
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin got = 1'b1; break; end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~in_valid;
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      if (perturb) begin
        start = ($urandom_range(0, 5) == 0);
        mode = 2'($urandom);
        num_windows = WIN_W'($urandom);
      end
      @(posedge clk); #1;
    end
    check(got, "layer_done_seen", int'(got), 1);
    start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check(!busy, "idle_after_done", int'(busy), 0);
  endtask

  // Abort a CONVOL layer during window 1's IFM load, two beats in.
  task automatic reset_abort;
    ev_t q[$];
    model_build(2'b01, 3, q);
    for (int i = 0; i < 24; i++) exp_q.push_back(q[i]);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; num_windows = WIN_W'(3); in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check({in_ready, buf_wr_en, buf_sel, buf_addr, pe_en, relu_en, pool_en, ofm_wr_en,
           ofm_addr, out_sel, busy, done, err} == '0, "outputs_after_abort",
          int'({buf_wr_en, busy, ofm_wr_en}), 0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check(exp_q.size() == 0, "abort_events_consumed", exp_q.size(), 0);
    exp_q = {};
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check({in_ready, buf_wr_en, pe_en, relu_en, pool_en, ofm_wr_en, out_sel, busy, done, err} == '0,
             "reset_outputs", int'({buf_wr_en, busy, done, err}), 0);
    rst = 1'b0;
    run_layer(2'b01, 1, 0, 1'b0);
    run_layer(2'b11, 3, 0, 1'b0);
    run_layer(2'b10, 2, 1, 1'b0);
    run_layer(2'b00, 2, 0, 1'b0);
    run_layer(2'b01, 0, 0, 1'b0);
    run_layer(2'b01, 2, 0, 1'b1);
    reset_abort();
    run_layer(2'b01, 1, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      run_layer(2'($urandom), int'($urandom_range(0, 4)), 2, 1'b1);
    repeat (4) @(posedge clk);
    #1 check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
